// File: rtl/dec_stage_pipe.sv
// Pipelined decode stage: valid/ready intake, scoreboarded register/bitmap reads with
// writeback bypass, and an ID/EX register with flush and HALT latching.
module dec_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int BM_W   = 1536,
  parameter int NBM    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_inst,
  output logic              if_ready,
  input  logic              flush,
  input  logic              wb_reg_en,
  input  logic [3:0]        wb_reg_addr,
  input  logic [DATA_W-1:0] wb_reg_data,
  input  logic              wb_bm_en,
  input  logic [1:0]        wb_bm_addr,
  input  logic [BM_W-1:0]   wb_bm_data,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [3:0]        id_op,
  output logic [3:0]        id_rd,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [BM_W-1:0]   id_bm_data,
  output logic              id_reg_write,
  output logic              id_bm_write,
  output logic              halted
);

  localparam int AW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int BAW = (NBM > 1) ? $clog2(NBM) : 1;

  typedef enum logic [3:0] {
    OP_NOP, OP_HALT, OP_SUB, OP_ADD, OP_BRR, OP_BR, OP_LD, OP_ST,
    OP_PLY, OP_MV, OP_BSL, OP_BSH, OP_RET, OP_SES, OP_STB, OP_LDB
  } op_e;

  typedef enum logic {S_RUN, S_HALTED} state_e;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [BM_W-1:0]   r_bms  [NBM];
  logic [NREGS-1:0]  r_pendReg, w_pendRegNext;
  logic [NBM-1:0]    r_pendBm, w_pendBmNext;
  state_e            r_state, w_stateNext;

  op_e               w_op;
  logic [AW-1:0]     w_rs1A, w_src2A, w_wbRegA;
  logic [1:0]        w_bmA;
  logic [BAW-1:0]    w_bmIdx, w_wbBmIdx, w_idBmIdx;
  logic              w_bmRdValid, w_wbBmValid, w_idBmValid;
  logic              w_useRs1, w_useRs2, w_useRd, w_useBm, w_useSrc2;
  logic              w_wrReg, w_wrBm;
  logic [DATA_W-1:0] w_imm, w_rs1Data, w_rs2Data;
  logic [BM_W-1:0]   w_bmData;
  logic              w_hit1, w_hit2, w_hitBm, w_hazard;
  logic              w_xfer, w_load, w_issue;

  assign w_op        = op_e'(if_inst[15:12]);
  assign w_rs1A      = if_inst[AW+3:4];
  assign w_bmA       = if_inst[11:10];
  assign w_bmIdx     = w_bmA[BAW-1:0];
  assign w_bmRdValid = ({30'd0, w_bmA} < NBM);
  assign w_wbRegA    = wb_reg_addr[AW-1:0];
  assign w_wbBmIdx   = wb_bm_addr[BAW-1:0];
  assign w_wbBmValid = ({30'd0, wb_bm_addr} < NBM);
  assign w_idBmIdx   = id_rd[BAW+1:2];
  assign w_idBmValid = ({30'd0, id_rd[3:2]} < NBM);

  always_comb begin
    w_useRs1 = 1'b0;
    w_useRs2 = 1'b0;
    w_useRd  = 1'b0;
    w_useBm  = 1'b0;
    w_wrReg  = 1'b0;
    w_wrBm   = 1'b0;
    w_imm    = DATA_W'($signed(if_inst[5:0]));
    case (w_op)
      OP_SUB, OP_ADD: begin w_useRs1 = 1'b1; w_useRs2 = 1'b1; w_wrReg = 1'b1; end
      OP_LD:  begin w_useRs1 = 1'b1; w_wrReg = 1'b1; w_imm = DATA_W'($signed(if_inst[3:0])); end
      OP_ST:  begin w_useRs1 = 1'b1; w_useRd = 1'b1; w_imm = DATA_W'($signed(if_inst[3:0])); end
      OP_MV:  begin w_wrReg = 1'b1; w_imm = DATA_W'($signed(if_inst[7:0])); end
      OP_BSL, OP_BSH: begin
        w_useRd = 1'b1;
        w_wrReg = 1'b1;
        w_imm   = DATA_W'($signed(if_inst[7:0]));
      end
      OP_STB: begin w_useRs1 = 1'b1; w_useBm = 1'b1; w_imm = DATA_W'($signed(if_inst[3:0])); end
      OP_LDB: begin w_useRs1 = 1'b1; w_wrBm = 1'b1; w_imm = DATA_W'($signed(if_inst[3:0])); end
      OP_PLY: w_useBm = 1'b1;
      OP_BRR: w_useRs1 = 1'b1;
      OP_BR:  w_imm = DATA_W'($signed(if_inst[8:0]));
      default: ;
    endcase
  end

  // The second operand carries rd when the instruction reads rd as a source (ST/BSL/BSH).
  assign w_useSrc2 = w_useRs2 | w_useRd;
  assign w_src2A   = w_useRd ? if_inst[AW+7:8] : if_inst[AW-1:0];

  assign w_hit1    = wb_reg_en && (w_wbRegA == w_rs1A);
  assign w_hit2    = wb_reg_en && (w_wbRegA == w_src2A);
  assign w_hitBm   = wb_bm_en && w_wbBmValid && (w_wbBmIdx == w_bmIdx);
  assign w_rs1Data = w_hit1 ? wb_reg_data : r_regs[w_rs1A];
  assign w_rs2Data = w_hit2 ? wb_reg_data : r_regs[w_src2A];
  assign w_bmData  = !w_bmRdValid ? '0 : (w_hitBm ? wb_bm_data : r_bms[w_bmIdx]);

  assign w_hazard = (w_useRs1 && r_pendReg[w_rs1A] && !w_hit1) ||
                    (w_useSrc2 && r_pendReg[w_src2A] && !w_hit2) ||
                    (w_useBm && w_bmRdValid && r_pendBm[w_bmIdx] && !w_hitBm);

  assign if_ready = (r_state == S_RUN) && !w_hazard && (!id_valid || ex_ready);
  assign halted   = (r_state == S_HALTED);
  assign w_xfer   = if_valid && if_ready;
  assign w_load   = w_xfer && !flush;
  assign w_issue  = id_valid && ex_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_RUN:    if (w_load && (w_op == OP_HALT)) w_stateNext = S_HALTED;
      S_HALTED: w_stateNext = S_HALTED;
      default:  w_stateNext = S_RUN;
    endcase
  end

  // Clear-then-set ordering lets an issuing writer win over a same-cycle writeback.
  always_comb begin
    w_pendRegNext = r_pendReg;
    w_pendBmNext  = r_pendBm;
    if (wb_reg_en) w_pendRegNext[w_wbRegA] = 1'b0;
    if (wb_bm_en && w_wbBmValid) w_pendBmNext[w_wbBmIdx] = 1'b0;
    if (w_issue && id_reg_write) w_pendRegNext[id_rd[AW-1:0]] = 1'b1;
    if (w_issue && id_bm_write && w_idBmValid) w_pendBmNext[w_idBmIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendReg <= '0;
      r_pendBm  <= '0;
    end else begin
      r_pendReg <= w_pendRegNext;
      r_pendBm  <= w_pendBmNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_reg_en) r_regs[w_wbRegA] <= wb_reg_data;
    if (!rst && wb_bm_en && w_wbBmValid) r_bms[w_wbBmIdx] <= wb_bm_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_op        <= '0;
      id_rd        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_bm_data   <= '0;
      id_reg_write <= 1'b0;
      id_bm_write  <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (w_load) begin
      id_valid     <= 1'b1;
      id_op        <= if_inst[15:12];
      id_rd        <= if_inst[11:8];
      id_rs1_data  <= w_rs1Data;
      id_rs2_data  <= w_rs2Data;
      id_imm       <= w_imm;
      id_bm_data   <= w_bmData;
      id_reg_write <= w_wrReg;
      id_bm_write  <= w_wrBm;
    end else if (ex_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Bench for dec_stage_pipe: random traffic against a behavioural decode model, directed
// literal checks, plus a narrow-parameter instance (NREGS=8, DATA_W=32, NBM=2).
module tb_dec_stage_pipe;

  logic          clk = 1'b0;
  logic          rst, if_valid, flush, wb_reg_en, wb_bm_en, ex_ready;
  logic [15:0]   if_inst, wb_reg_data;
  logic [3:0]    wb_reg_addr;
  logic [1:0]    wb_bm_addr;
  logic [1535:0] wb_bm_data;
  logic          if_ready, id_valid, id_reg_write, id_bm_write, halted;
  logic [3:0]    id_op, id_rd;
  logic [15:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [1535:0] id_bm_data;

  logic          d2IfValid, d2IfReady, d2WbRegEn, d2WbBmEn, d2IdValid;
  logic          d2RegW, d2BmW, d2Halted;
  logic [15:0]   d2IfInst;
  logic [3:0]    d2WbRegAddr, d2IdOp, d2IdRd;
  logic [31:0]   d2WbRegData, d2Rs1, d2Rs2, d2Imm;
  logic [1:0]    d2WbBmAddr;
  logic [7:0]    d2WbBmData, d2Bm;

  int nCompared = 0;
  int nMismatch = 0;

  // Behavioural model state
  logic [15:0]   mRegs [16];
  logic [1535:0] mBm [4];
  bit            mPendR [16];
  bit            mPendB [4];
  bit            mHalted = 1'b0;
  bit            mValid = 1'b0;
  bit            mRegW = 1'b0, mBmW = 1'b0;
  logic [3:0]    mOp = '0, mRd = '0;
  logic [15:0]   mRs1 = '0, mRs2 = '0, mImm = '0;
  logic [1535:0] mBmD = '0;

  always #5 clk = ~clk;

  dec_stage_pipe u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .flush(flush), .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .wb_bm_en(wb_bm_en), .wb_bm_addr(wb_bm_addr), .wb_bm_data(wb_bm_data),
    .id_valid(id_valid), .ex_ready(ex_ready), .id_op(id_op), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_bm_data(id_bm_data), .id_reg_write(id_reg_write), .id_bm_write(id_bm_write),
    .halted(halted)
  );

  dec_stage_pipe #(.DATA_W(32), .NREGS(8), .BM_W(8), .NBM(2)) u_dut2 (
    .clk(clk), .rst(rst), .if_valid(d2IfValid), .if_inst(d2IfInst), .if_ready(d2IfReady),
    .flush(1'b0), .wb_reg_en(d2WbRegEn), .wb_reg_addr(d2WbRegAddr), .wb_reg_data(d2WbRegData),
    .wb_bm_en(d2WbBmEn), .wb_bm_addr(d2WbBmAddr), .wb_bm_data(d2WbBmData),
    .id_valid(d2IdValid), .ex_ready(1'b1), .id_op(d2IdOp), .id_rd(d2IdRd),
    .id_rs1_data(d2Rs1), .id_rs2_data(d2Rs2), .id_imm(d2Imm),
    .id_bm_data(d2Bm), .id_reg_write(d2RegW), .id_bm_write(d2BmW), .halted(d2Halted)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Operand usage and immediate width straight from the opcode table.
  function automatic void specDecode(input logic [15:0] inst, output bit u1, output bit u2,
                                     output bit uRd, output bit uBm, output bit wReg,
                                     output bit wBm, output logic [15:0] imm);
    int op;
    int bits;
    op   = int'(inst[15:12]);
    u1   = op inside {2, 3, 4, 6, 7, 14, 15};
    u2   = op inside {2, 3};
    uRd  = op inside {7, 10, 11};
    uBm  = op inside {8, 14};
    wReg = op inside {2, 3, 6, 9, 10, 11};
    wBm  = (op == 15);
    bits = (op == 5) ? 9 : (op inside {6, 7, 14, 15}) ? 4 : (op inside {9, 10, 11}) ? 8 : 6;
    imm  = 16'(sext(int'(inst) & ((1 << bits) - 1), bits));
  endfunction

  function automatic logic [15:0] readReg(input logic [3:0] a);
    return (wb_reg_en && wb_reg_addr == a) ? wb_reg_data : mRegs[a];
  endfunction

  function automatic logic [1535:0] readBm(input logic [1:0] a);
    return (wb_bm_en && wb_bm_addr == a) ? wb_bm_data : mBm[a];
  endfunction

  function automatic bit waiting(input logic [3:0] a);
    return mPendR[a] && !(wb_reg_en && wb_reg_addr == a);
  endfunction

  function automatic bit modelIfReady();
    bit u1, u2, uRd, uBm, wReg, wBm, haz;
    logic [15:0] imm;
    specDecode(if_inst, u1, u2, uRd, uBm, wReg, wBm, imm);
    haz = (u1 && waiting(if_inst[7:4])) || (u2 && waiting(if_inst[3:0])) ||
          (uRd && waiting(if_inst[11:8])) ||
          (uBm && mPendB[if_inst[11:10]] && !(wb_bm_en && wb_bm_addr == if_inst[11:10]));
    return !mHalted && !haz && (!mValid || ex_ready);
  endfunction

  task automatic modelUpdate();
    bit u1, u2, uRd, uBm, wReg, wBm, xfer;
    logic [15:0] imm;
    if (rst) begin
      mValid = 0; mHalted = 0; mRegW = 0; mBmW = 0;
      mOp = '0; mRd = '0; mRs1 = '0; mRs2 = '0; mImm = '0; mBmD = '0;
      foreach (mPendR[i]) mPendR[i] = 0;
      foreach (mPendB[i]) mPendB[i] = 0;
      return;
    end
    xfer = if_valid && modelIfReady();
    specDecode(if_inst, u1, u2, uRd, uBm, wReg, wBm, imm);
    if (wb_reg_en) mPendR[wb_reg_addr] = 0;
    if (wb_bm_en) mPendB[wb_bm_addr] = 0;
    if (mValid && ex_ready && mRegW) mPendR[mRd] = 1;
    if (mValid && ex_ready && mBmW) mPendB[mRd[3:2]] = 1;
    if (flush) mValid = 0;
    else if (xfer) begin
      mValid = 1;
      mOp    = if_inst[15:12];
      mRd    = if_inst[11:8];
      mRs1   = readReg(if_inst[7:4]);
      mRs2   = uRd ? readReg(if_inst[11:8]) : readReg(if_inst[3:0]);
      mImm   = imm;
      mBmD   = readBm(if_inst[11:10]);
      mRegW  = wReg;
      mBmW   = wBm;
      if (if_inst[15:12] == 4'h1) mHalted = 1;
    end else if (ex_ready) mValid = 0;
    if (wb_reg_en) mRegs[wb_reg_addr] = wb_reg_data;
    if (wb_bm_en) mBm[wb_bm_addr] = wb_bm_data;
  endtask

  task automatic checkOutput();
    cmp("if_ready", 64'(if_ready), 64'(modelIfReady()));
    cmp("halted", 64'(halted), 64'(mHalted));
    cmp("id_valid", 64'(id_valid), 64'(mValid));
    if (mValid) begin
      cmp("id_op", 64'(id_op), 64'(mOp));
      cmp("id_rd", 64'(id_rd), 64'(mRd));
      cmp("id_rs1_data", 64'(id_rs1_data), 64'(mRs1));
      cmp("id_rs2_data", 64'(id_rs2_data), 64'(mRs2));
      cmp("id_imm", 64'(id_imm), 64'(mImm));
      cmp("id_reg_write", 64'(id_reg_write), 64'(mRegW));
      cmp("id_bm_write", 64'(id_bm_write), 64'(mBmW));
      nCompared++;
      if (id_bm_data !== mBmD) begin
        nMismatch++;
        $display("[TB] FAIL id_bm_data at %0t: got low word %0h expected low word %0h", $time,
                 id_bm_data[31:0], mBmD[31:0]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic fillRand(output logic [1535:0] v);
    for (int i = 0; i < 48; i++) v[i*32 +: 32] = $urandom;
  endtask

  task automatic applyStimulus();
    int op;
    int start;
    op = $urandom_range(0, 14);
    if (op >= 1) op++;
    rst      = ($urandom_range(0, 499) == 0);
    if_valid = ($urandom_range(0, 3) != 0);
    if_inst  = {4'(op), 12'($urandom)};
    ex_ready = ($urandom_range(0, 3) != 0);
    flush    = ($urandom_range(0, 15) == 0);
    wb_reg_en   = $urandom_range(0, 1);
    wb_reg_addr = 4'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      start = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++)
        if (mPendR[(start + i) % 16]) wb_reg_addr = 4'((start + i) % 16);
    end
    wb_reg_data = 16'($urandom);
    wb_bm_en    = ($urandom_range(0, 3) == 0);
    wb_bm_addr  = 2'($urandom);
    fillRand(wb_bm_data);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1535:0] tmp;
    rst = 1; if_valid = 0; if_inst = '0; flush = 0; ex_ready = 1;
    wb_reg_en = 0; wb_reg_addr = '0; wb_reg_data = '0;
    wb_bm_en = 0; wb_bm_addr = '0; wb_bm_data = '0;
    d2IfValid = 0; d2IfInst = '0; d2WbRegEn = 0; d2WbRegAddr = '0; d2WbRegData = '0;
    d2WbBmEn = 0; d2WbBmAddr = '0; d2WbBmData = '0;
    foreach (mPendR[i]) mPendR[i] = 0;
    foreach (mPendB[i]) mPendB[i] = 0;
    tick();
    tick();
    rst = 0;
    #1;
    cmp("reset id_valid", 64'(id_valid), 64'd0);
    cmp("reset halted", 64'(halted), 64'd0);
    cmp("reset if_ready", 64'(if_ready), 64'd1);
    cmp("reset id_op", 64'(id_op), 64'd0);
    cmp("reset id_rs1_data", 64'(id_rs1_data), 64'd0);
    cmp("reset id_bm_data", 64'(|id_bm_data), 64'd0);

    wb_reg_en = 1;
    for (int r = 0; r < 16; r++) begin
      wb_reg_addr = 4'(r);
      wb_reg_data = (r == 3) ? 16'h1234 : 16'($urandom);
      tick();
    end
    wb_reg_en = 0;
    wb_bm_en = 1;
    for (int b = 0; b < 4; b++) begin
      wb_bm_addr = 2'(b);
      fillRand(tmp);
      wb_bm_data = tmp;
      tick();
    end
    wb_bm_en = 0;

    if_inst = 16'h3133; if_valid = 1;
    #1 cmp("add offer if_ready", 64'(if_ready), 64'd1);
    tick();
    if_valid = 0;
    cmp("add id_valid", 64'(id_valid), 64'd1);
    cmp("add id_rs1_data", 64'(id_rs1_data), 64'h1234);
    cmp("add id_rs2_data", 64'(id_rs2_data), 64'h1234);
    cmp("add id_reg_write", 64'(id_reg_write), 64'd1);

    if_inst = 16'h6205; if_valid = 1;
    tick();
    if_valid = 0;
    tick();
    if_inst = 16'h3422; if_valid = 1;
    #1 cmp("raw stall if_ready", 64'(if_ready), 64'd0);
    tick();
    cmp("raw stall if_ready 2", 64'(if_ready), 64'd0);
    tick();
    wb_reg_en = 1; wb_reg_addr = 4'h2; wb_reg_data = 16'h00AA;
    #1 cmp("wb release if_ready", 64'(if_ready), 64'd1);
    tick();
    wb_reg_en = 0; if_valid = 0;
    cmp("bypass id_rs1_data", 64'(id_rs1_data), 64'h00AA);
    cmp("bypass id_op", 64'(id_op), 64'd3);

    if_inst = 16'h51F0; if_valid = 1;
    tick();
    cmp("br id_imm", 64'(id_imm), 64'hFFF0);
    if_inst = 16'h957F;
    tick();
    if_valid = 0;
    cmp("mv id_imm", 64'(id_imm), 64'h007F);

    ex_ready = 0; if_inst = 16'h2700; if_valid = 1;
    #1 cmp("hold if_ready", 64'(if_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("hold if_ready", 64'(if_ready), 64'd0);
      cmp("hold id_valid", 64'(id_valid), 64'd1);
      cmp("hold id_op", 64'(id_op), 64'd9);
      cmp("hold id_imm", 64'(id_imm), 64'h007F);
    end
    ex_ready = 1;
    #1 cmp("resume if_ready", 64'(if_ready), 64'd1);
    tick();
    if_valid = 0;
    cmp("resume id_op", 64'(id_op), 64'd2);
    cmp("resume id_rd", 64'(id_rd), 64'd7);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick();
    end
    rst = 0; if_valid = 0; flush = 0; ex_ready = 1; wb_reg_en = 0; wb_bm_en = 0;
    tick();
    tick();

    if_inst = 16'h1000; if_valid = 1; flush = 1;
    #1 cmp("halt+flush if_ready", 64'(if_ready), 64'd1);
    tick();
    flush = 0;
    cmp("halt+flush halted", 64'(halted), 64'd0);
    cmp("halt+flush id_valid", 64'(id_valid), 64'd0);
    tick();
    cmp("halt halted", 64'(halted), 64'd1);
    cmp("halt if_ready", 64'(if_ready), 64'd0);
    cmp("halt id_op", 64'(id_op), 64'd1);
    if_inst = 16'h3133;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("halted sticky", 64'(halted), 64'd1);
      cmp("halted if_ready", 64'(if_ready), 64'd0);
    end
    rst = 1;
    tick();
    rst = 0; if_valid = 0;
    #1;
    cmp("post-rst halted", 64'(halted), 64'd0);
    cmp("post-rst if_ready", 64'(if_ready), 64'd1);

    d2WbRegEn = 1; d2WbRegAddr = 4'hB; d2WbRegData = 32'hCAFEF00D;
    tick();
    d2WbRegEn = 0;
    d2WbBmEn = 1; d2WbBmAddr = 2'd3; d2WbBmData = 8'hFF;
    tick();
    d2WbBmAddr = 2'd1; d2WbBmData = 8'h5A;
    tick();
    d2WbBmEn = 0;
    d2IfInst = 16'h3133; d2IfValid = 1;
    #1 cmp("narrow if_ready", 64'(d2IfReady), 64'd1);
    tick();
    cmp("narrow rs1 from 0xB", 64'(d2Rs1), 64'hCAFEF00D);
    cmp("narrow rs2 from 0xB", 64'(d2Rs2), 64'hCAFEF00D);
    d2IfInst = 16'h5100;
    tick();
    cmp("narrow br id_imm", 64'(d2Imm), 64'hFFFFFF00);
    d2IfInst = 16'h8C00;
    tick();
    cmp("narrow bm out of range", 64'(d2Bm), 64'h0);
    d2IfInst = 16'h8400;
    tick();
    cmp("narrow bm1", 64'(d2Bm), 64'h5A);
    d2IfValid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/dec_stage_pipe.md
Name: dec_stage_pipe

Overview:
Parametrised, pipelined successor to the combinational decode stage. Accepts fetched instructions over a valid/ready handshake, reads the register and bitmap files, and registers decoded controls and operands into an ID/EX pipeline register. Adds a write-pending scoreboard for hazard stalls, write-to-read bypass, flush and HALT latching. Sits between fetch and execute in the CPU pipeline.

Parameters:
DATA_W, 16, scalar register width (fixed 16-bit instruction; immediates sign-extend to DATA_W)
NREGS, 16, scalar register count (power of two, ≤16; addresses use low log2(NREGS) bits of 4-bit fields)
BM_W, 1536, bitmap register width
NBM, 4, bitmap register count (≤4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch offers inst
if_inst  in  16  instruction
if_ready  out  1  decode accepts this cycle
flush  in  1  discard ID/EX contents and the inst offered this cycle
wb_reg_en  in  1  scalar writeback strobe
wb_reg_addr  in  4  scalar writeback address
wb_reg_data  in  DATA_W  scalar writeback data
wb_bm_en  in  1  bitmap writeback strobe
wb_bm_addr  in  2  bitmap writeback address
wb_bm_data  in  BM_W  bitmap writeback data
id_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  execute consumes ID/EX this cycle
id_op  out  4  opcode
id_rd  out  4  destination address, inst[11:8]
id_rs1_data  out  DATA_W  operand 1
id_rs2_data  out  DATA_W  operand 2
id_imm  out  DATA_W  sign-extended immediate
id_bm_data  out  BM_W  bitmap operand
id_reg_write  out  1  instruction writes a scalar register
id_bm_write  out  1  instruction writes a bitmap
halted  out  1  HALT has issued

Behaviour:
- Opcodes: 0 NOP, 1 HALT, 2 SUB, 3 ADD, 4 BRR, 5 BR, 6 LD, 7 ST, 8 PLY, 9 MV, A BSL, B BSH, C RET, D SES, E STB, F LDB.
- Fields: rs1=inst[7:4], rs2=inst[3:0], rd=inst[11:8], bm=inst[11:10]. ADD/SUB use rs1,rs2 and write rd. LD uses rs1 and writes rd. ST uses rs1 and rd-as-source. MV writes rd. BSL/BSH use rd and write rd. STB uses rs1 and bitmap bm. LDB uses rs1 and writes bitmap bm. PLY reads bitmap bm. BRR uses rs1.
- Immediate: BR sign-extends 9 bits inst[8:0]. LD/ST/LDB/STB sign-extend inst[3:0]. MV/BSL/BSH sign-extend inst[7:0]. All others sign-extend 6 bits inst[5:0].
- Register files are internal, written on clk. A read of an address being written the same cycle returns wb data (bypass).
- Scoreboard: one pending bit per scalar register and per bitmap.
  - Set on issue (id_valid & ex_ready) of a writing instruction.
  - Cleared when wb_*_en targets that entry.
  - Same-cycle set and clear on one entry: set wins.
- Stall: if_ready=0 when any used source is pending and not being written back this cycle, when ID/EX is full and ex_ready=0, or when halted.
- Transfer: occurs when if_valid & if_ready. The ID/EX register loads and id_valid=1 on the next edge. With ex_ready held at 1, throughput is 1 instruction/cycle and latency is 1 cycle.
- ID/EX outputs hold stable while id_valid & !ex_ready.
- flush: on the next edge, id_valid=0. The offered instruction is not accepted. The scoreboard is untouched; in-flight writebacks still clear their entries. flush beats a simultaneous transfer.
- State machine RUN→HALTED on transfer of HALT. In HALTED, if_ready=0 and halted=1; the state is left only by rst. A flush in the same cycle as HALT transfer cancels it, and the state stays RUN.
- Reset (sync, rst=1 at edge): all outputs 0, id_valid=0, halted=0, scoreboard cleared, state RUN. Register file contents are not reset. rst overrides flush, wb and handshake.
- Narrow parameters: register addresses are truncated to log2(NREGS) bits. Bitmap addresses at or above NBM read 0 and ignore writes.

Test Plan:
- Reset, wb r3=0x1234, then ADD r1,r3,r3 with ex_ready=1 -> next cycle id_valid=1, id_rs1_data=id_rs2_data=0x1234, id_reg_write=1.
- LD r2 issues; ADD r4,r2,r2 offered -> if_ready=0 until wb_reg_en r2=0x00AA. In that wb cycle if_ready=1 and bypass gives id_rs1_data=0x00AA.
- BR with inst[8:0]=0x1F0 -> id_imm=0xFFF0. MV with inst[7:0]=0x7F -> id_imm=0x007F.
- ex_ready=0 for 3 cycles with id_valid=1 -> ID/EX outputs unchanged and if_ready=0. ex_ready=1 -> the next offered instruction loads.
- HALT transferred -> halted=1 and if_ready=0 permanently. rst -> halted=0 and if_ready=1. HALT with flush in the same cycle -> halted stays 0.
- NREGS=8, DATA_W=32: wb addr 0xB writes r3. BR imm 0x100 -> id_imm=0xFFFFFF00.
